// File: rtl/msk_input_encoder.sv
// msk_input_encoder: turns one unmasked 128-bit plaintext/key pair into d-share
// Boolean masked form, using NW fresh PRNG words per encoding.
// Latency: out_valid rises NW+1 cycles after the input handshake with continuous
// rnd_valid; no overlap, so at most one encoding per NW+2 cycles.
// Backpressure: out_valid and sh_* hold until out_ready; in_ready/rnd_ready/
// out_valid/busy are decoded from state only (and forced low during rst).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        plaintext/key handshake
//   plaintext, key           unmasked 128-bit inputs
//   rnd_in/rnd_valid/rnd_ready  PRNG word stream (RND_W bits)
//   out_valid/out_ready      shares handshake towards the masked AES core
//   sh_plaintext, sh_key     bit-interleaved shares (share j of bit i at d*i+j)
//   busy                     high whenever not IDLE
//
// Parameter constraints: d >= 2, and 256*(d-1) divisible by RND_W.

module msk_input_encoder #(
  parameter int d     = 2,
  parameter int RND_W = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       plaintext,
  input  logic [127:0]       key,
  input  logic [RND_W-1:0]   rnd_in,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [128*d-1:0]   sh_plaintext,
  output logic [128*d-1:0]   sh_key,
  output logic               busy
);

  localparam int RW = 256 * (d - 1);           // mask pool width
  localparam int NW = RW / RND_W;              // PRNG words per encoding
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

  state_t        state, state_nxt;
  logic [127:0]  pt_q, key_q;
  logic [RW-1:0] r_q;
  logic [CW-1:0] cnt;
  logic [127:0]  p_mask_x, k_mask_x;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = COLLECT;
      COLLECT: if (rnd_valid && (cnt == CW'(NW - 1))) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: state decode only, held low while rst is asserted so the
  // upstream/downstream never see a ready/valid during reset.
  always_comb begin
    in_ready  = 1'b0;
    rnd_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = 1'b1;
        COLLECT: begin rnd_ready = 1'b1; busy = 1'b1; end
        OUT:     begin out_valid = 1'b1; busy = 1'b1; end
        default: ;
      endcase
    end
  end

  // Datapath: latch inputs, fill the mask pool word by word, and wipe all
  // secret-bearing registers once the shares have been handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_q  <= '0;
      key_q <= '0;
      r_q   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pt_q  <= plaintext;
            key_q <= key;
            cnt   <= '0;
          end
        end
        COLLECT: begin
          if (rnd_valid) begin
            for (int k = 0; k < NW; k++) begin
              if (cnt == CW'(k)) r_q[k*RND_W +: RND_W] <= rnd_in;
            end
            // Wraps only via the state change; never compared past NW-1.
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            pt_q  <= '0;
            key_q <= '0;
            r_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Share formation. Masks for the plaintext occupy the lower 128*(d-1) bits of
  // the pool, key masks the upper half; share 0 absorbs the XOR of all masks.
  always_comb begin
    p_mask_x     = '0;
    k_mask_x     = '0;
    sh_plaintext = '0;
    sh_key       = '0;
    for (int j = 1; j < d; j++) begin
      p_mask_x = p_mask_x ^ r_q[(j-1)*128 +: 128];
      k_mask_x = k_mask_x ^ r_q[(d-1)*128 + (j-1)*128 +: 128];
    end
    for (int i = 0; i < 128; i++) begin
      sh_plaintext[d*i] = pt_q[i] ^ p_mask_x[i];
      sh_key[d*i]       = key_q[i] ^ k_mask_x[i];
      for (int j = 1; j < d; j++) begin
        sh_plaintext[d*i+j] = r_q[(j-1)*128 + i];
        sh_key[d*i+j]       = r_q[(d-1)*128 + (j-1)*128 + i];
      end
    end
  end

endmodule
